// File: rtl/pll_seq_pkg.sv
// Shared state encoding, default timing constants and output decode for the
// PLL reset sequencer.
package pll_seq_pkg;

  localparam logic [2:0] ST_PLL_RST   = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_STABLE    = 3'd2;
  localparam logic [2:0] ST_VGA_UP    = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_FAULT     = 3'd5;

  localparam int DEF_PLL_RST_CYCLES     = 4;
  localparam int DEF_LOCK_STABLE_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT       = 1024;
  localparam int DEF_GAME_DELAY         = 8;
  localparam int DEF_MAX_RETRIES        = 3;

  typedef struct packed {
    logic pll_rst;
    logic vga_rst_n;
    logic game_rst_n;
    logic sys_ready;
    logic fault;
  } seq_out_t;

  // Moore decode: outputs are a pure function of the state they accompany.
  function automatic seq_out_t decode_state(input logic [2:0] st);
    seq_out_t o;
    o.pll_rst    = (st == ST_PLL_RST) || (st == ST_FAULT);
    o.vga_rst_n  = (st == ST_VGA_UP)  || (st == ST_RUN);
    o.game_rst_n = (st == ST_RUN);
    o.sys_ready  = (st == ST_RUN);
    o.fault      = (st == ST_FAULT);
    return o;
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Loadable cycle counter: synchronous clear, count enable and a terminal-count
// flag against a limit that the owner may change every cycle.
module seq_timer #(
  parameter int CNT_W = 11
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) r_cnt <= '0;
    else if (i_en)         r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == i_limit);

endmodule

// File: rtl/pll_reset_sequencer.sv
// Power-up reset sequencer: pulses the PLL, waits for a stable lock, then
// releases the VGA and game domains in order, retrying or faulting on timeout.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int GAME_DELAY         = DEF_GAME_DELAY,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       vga_rst_n,
  output logic       game_rst_n,
  output logic       sys_ready,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [2:0] state
);

  localparam int CNT_MAX = max_of(max_of(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                  max_of(LOCK_TIMEOUT, GAME_DELAY));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRIES);

  logic [2:0]       r_state;
  logic [1:0]       r_retry;
  seq_out_t         r_out;

  logic [2:0]       w_nxt;
  logic [1:0]       w_retry_nxt;
  logic [CNT_W-1:0] w_limit;
  logic             w_tc;
  logic             w_en;
  logic             w_clr;

  // STABLE compares against the full count so the lock has to be seen one
  // extra cycle; that places VGA release at lock edge + 1 + LOCK_STABLE_CYCLES.
  always_comb begin
    w_limit = '0;
    w_en    = 1'b1;
    case (r_state)
      ST_PLL_RST:   w_limit = CNT_W'(PLL_RST_CYCLES - 1);
      ST_WAIT_LOCK: w_limit = CNT_W'(LOCK_TIMEOUT - 1);
      ST_STABLE:    w_limit = CNT_W'(LOCK_STABLE_CYCLES);
      ST_VGA_UP:    w_limit = CNT_W'(GAME_DELAY - 1);
      default:      w_en    = 1'b0;
    endcase
  end

  always_comb begin
    w_nxt       = r_state;
    w_retry_nxt = r_retry;
    case (r_state)
      ST_PLL_RST: begin
        if (w_tc) w_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (pll_locked) w_nxt = ST_STABLE;
        else if (w_tc) begin
          if (r_retry < RETRY_MAX) begin
            w_retry_nxt = r_retry + 2'd1;
            w_nxt       = ST_PLL_RST;
          end else begin
            w_nxt = ST_FAULT;
          end
        end
      end
      ST_STABLE: begin
        if (!pll_locked) w_nxt = ST_WAIT_LOCK;
        else if (w_tc)   w_nxt = ST_VGA_UP;
      end
      ST_VGA_UP: begin
        if (!pll_locked) w_nxt = ST_WAIT_LOCK;
        else if (w_tc) begin
          w_nxt       = ST_RUN;
          w_retry_nxt = 2'd0;
        end
      end
      ST_RUN: begin
        if (!pll_locked) w_nxt = ST_WAIT_LOCK;
      end
      ST_FAULT: w_nxt = ST_FAULT;
      default:  w_nxt = ST_PLL_RST;
    endcase
  end

  assign w_clr = (w_nxt != r_state);

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk   (refclk),
    .i_rst_n (rst_n),
    .i_clr   (w_clr),
    .i_en    (w_en),
    .i_limit (w_limit),
    .o_tc    (w_tc)
  );

  // Outputs are decoded from the next state so they move with the state reg.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      r_state <= ST_PLL_RST;
      r_retry <= 2'd0;
      r_out   <= decode_state(ST_PLL_RST);
    end else begin
      r_state <= w_nxt;
      r_retry <= w_retry_nxt;
      r_out   <= decode_state(w_nxt);
    end
  end

  assign pll_rst     = r_out.pll_rst;
  assign vga_rst_n   = r_out.vga_rst_n;
  assign game_rst_n  = r_out.game_rst_n;
  assign sys_ready   = r_out.sys_ready;
  assign fault       = r_out.fault;
  assign retry_count = r_retry;
  assign state       = r_state;

endmodule
